// File: rtl/dot_fp8_seq.sv
// dot_fp8_seq: streams FP8 vector chunks through one dot_fp8 and accumulates a long dot product.
//   i_clk/i_rst_n             clock, asynchronous active-low reset
//   i_start/i_num_chunks      job request (IDLE only), chunk count clamped to max_chunks
//   o_busy                    high outside IDLE
//   i_vec_valid/o_vec_ready   chunk handshake carrying i_vec_a/i_vec_b (k FP8 lanes each)
//   o_res_valid/i_res_ready   result handshake carrying o_res (o_dp scaling) and sticky o_nan
module dot_fp8 #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int k = 32,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int dp_width = 2 * ((1 << exp_width) + man_width + 2) + $clog2(k)
)(
  input  logic [k-1:0][bit_width-1:0] i_a,
  input  logic [k-1:0][bit_width-1:0] i_b,
  output logic signed [dp_width-1:0]  o_dp,
  output logic                        o_nan
);
  logic signed [dp_width-1:0] prod [k];
  logic [k-1:0] spec;
  // LSB weight is the square of the smallest subnormal step; all-ones exponent lanes are flagged and contribute 0
  for (genvar l = 0; l < k; l++) begin : g_lane
    logic [exp_width-1:0] ea, eb;
    logic [man_width:0] ma, mb;
    logic [exp_width:0] sh;
    logic [dp_width-1:0] mag;
    assign ea = i_a[l][bit_width-2 -: exp_width];
    assign eb = i_b[l][bit_width-2 -: exp_width];
    assign ma = {|ea, i_a[l][man_width-1:0]};
    assign mb = {|eb, i_b[l][man_width-1:0]};
    assign sh = {1'b0, ea - exp_width'(|ea)} + {1'b0, eb - exp_width'(|eb)};
    assign mag = (dp_width'(ma) * dp_width'(mb)) << sh;
    assign spec[l] = &ea | &eb;
    assign prod[l] = spec[l] ? '0 : ((i_a[l][bit_width-1] ^ i_b[l][bit_width-1]) ? -$signed(mag) : $signed(mag));
  end
  always_comb begin
    o_dp = '0;
    for (int i = 0; i < k; i++) o_dp = o_dp + prod[i];
  end
  assign o_nan = |spec;
endmodule

module dot_fp8_seq #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int k = 32,
  parameter int max_chunks = 16,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int dp_width = 2 * ((1 << exp_width) + man_width + 2) + $clog2(k),
  localparam int acc_width = dp_width + $clog2(max_chunks),
  localparam int cnt_width = $clog2(max_chunks + 1)
)(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [cnt_width-1:0]         i_num_chunks,
  output logic                         o_busy,
  input  logic                         i_vec_valid,
  output logic                         o_vec_ready,
  input  logic [k-1:0][bit_width-1:0]  i_vec_a,
  input  logic [k-1:0][bit_width-1:0]  i_vec_b,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic signed [acc_width-1:0]  o_res,
  output logic                         o_nan
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [cnt_width-1:0] num_q, cnt, n;
  logic signed [dp_width-1:0] dp, p1_dp;
  logic signed [acc_width-1:0] acc;
  logic dnan, p1_nan, p1_vld, nan_q, hs, go;
  dot_fp8 #(.exp_width(exp_width), .man_width(man_width), .k(k)) u_dot (
    .i_a(i_vec_a), .i_b(i_vec_b), .o_dp(dp), .o_nan(dnan)
  );
  assign n = i_num_chunks > cnt_width'(max_chunks) ? cnt_width'(max_chunks) : i_num_chunks;
  assign hs = i_vec_valid & o_vec_ready;
  assign go = state == IDLE && i_start;
  always_comb begin
    nxt = state;
    if (go) nxt = n == 0 ? DONE : LOAD;
    if (state == LOAD && hs && cnt + 1'b1 == num_q) nxt = DRAIN;
    if (state == DRAIN) nxt = DONE;
    if (state == DONE && i_res_ready) nxt = IDLE;
  end
  assign o_busy = state != IDLE;
  assign o_vec_ready = state == LOAD;
  assign o_res_valid = state == DONE;
  assign o_res = acc;
  assign o_nan = nan_q;
  // Accumulator and sticky flag are cleared at every accepted start, so zero-length jobs report 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      num_q <= '0;
      cnt <= '0;
      p1_dp <= '0;
      p1_nan <= 1'b0;
      p1_vld <= 1'b0;
      acc <= '0;
      nan_q <= 1'b0;
    end else begin
      state <= nxt;
      p1_vld <= hs;
      if (hs) begin
        p1_dp <= dp;
        p1_nan <= dnan;
        cnt <= cnt + 1'b1;
      end
      if (go) begin
        num_q <= n;
        cnt <= '0;
        acc <= '0;
        nan_q <= 1'b0;
      end else if (p1_vld) begin
        acc <= acc + acc_width'(p1_dp);
        nan_q <= nan_q | p1_nan;
      end
    end
  end
endmodule

// File: tb/tb_dot_fp8_seq.sv
// tb_dot_fp8_seq: randomized self-checking bench for dot_fp8_seq against a real-value FP8 reference.
module tb_dot_fp8_seq;
  localparam int K = 32, MAXC = 16, AW = 81;
  logic clk = 0, rst_n = 0, start = 0, vec_valid = 0, res_ready = 0;
  logic [4:0] num = 0;
  logic busy, vec_ready, res_valid, nan;
  logic [K-1:0][7:0] va, vb;
  logic signed [AW-1:0] res;
  logic [7:0] ca [MAXC][K];
  logic [7:0] cb [MAXC][K];
  logic signed [127:0] d_one;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dot_fp8_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_chunks(num), .o_busy(busy),
    .i_vec_valid(vec_valid), .o_vec_ready(vec_ready), .i_vec_a(va), .i_vec_b(vb),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res(res), .o_nan(nan)
  );

  // Value of an e5m2 byte in units of 2^-16 (smallest subnormal step); specials count as 0
  function automatic logic signed [127:0] fval(input logic [7:0] x);
    int e, m;
    logic signed [127:0] v;
    e = int'(x[6:2]);
    m = int'(x[1:0]);
    if (e == 31) return 0;
    v = (e == 0) ? 128'(m) : (128'(m + 4) <<< (e - 1));
    return x[7] ? -v : v;
  endfunction

  function automatic int eff(input int n);
    return n > MAXC ? MAXC : n;
  endfunction

  function automatic logic signed [127:0] model_res(input int n);
    logic signed [127:0] s = 0;
    for (int c = 0; c < eff(n); c++)
      for (int l = 0; l < K; l++) s += fval(ca[c][l]) * fval(cb[c][l]);
    return s;
  endfunction

  function automatic logic model_nan(input int n);
    logic f = 0;
    for (int c = 0; c < eff(n); c++)
      for (int l = 0; l < K; l++) f |= (ca[c][l][6:2] == 5'h1f) | (cb[c][l][6:2] == 5'h1f);
    return f;
  endfunction

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int c = 0; c < MAXC; c++)
      for (int l = 0; l < K; l++) begin
        ca[c][l] = a;
        cb[c][l] = b;
      end
  endtask

  task automatic fill_rand(input bit allow_spec);
    logic [7:0] x;
    for (int c = 0; c < MAXC; c++)
      for (int l = 0; l < K; l++) begin
        x = 8'($urandom);
        if (x[6:2] == 5'h1f) x[6:2] = 5'h1e;
        ca[c][l] = x;
        x = 8'($urandom);
        if (x[6:2] == 5'h1f) x[6:2] = 5'h1e;
        cb[c][l] = x;
      end
    if (allow_spec && $urandom_range(2) == 0)
      ca[$urandom_range(MAXC - 1)][$urandom_range(K - 1)] = 8'h7d;
  endtask

  // mode 0: valid held high, 1: random bubbles, 2: fixed pattern 1,0,0,1,0,1
  task automatic run_job(input int n, input int mode, input bit pulse,
                         output int hs, output int rdy, output int lat);
    logic [5:0] pat = 6'b101001;
    int last = -1;
    hs = 0; rdy = 0; lat = -1;
    start = 1; num = 5'(n);
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 3000; c++) begin
      if (res_valid) begin
        lat = c - last;
        break;
      end
      vec_valid = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(2) != 0) : pat[c % 6];
      for (int l = 0; l < K; l++) begin
        va[l] = hs < eff(n) ? ca[hs][l] : 8'h7c;
        vb[l] = hs < eff(n) ? cb[hs][l] : 8'h7c;
      end
      start = pulse && c == 1;
      if (pulse && c == 1) num = 5'd1;
      if (vec_ready) rdy++;
      if (vec_valid && vec_ready) begin
        hs++;
        last = c;
      end
      @(negedge clk);
    end
    vec_valid = 0; start = 0;
  endtask

  task automatic release_res;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, vec_ready, res_valid, nan} !== 4'b0 || res !== '0) begin
      errors++;
      $display("FAIL reset_state: flags=%b res=%0d, required flags=0000 res=0", {busy, vec_ready, res_valid, nan}, res);
    end
    rst_n = 1;
    vec_valid = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (vec_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_start_ready: vec_ready=%b busy=%b, required 0 0", vec_ready, busy);
      end
    end
    vec_valid = 0;
  endtask

  task automatic test_stream_pos;
    int hs, rdy, lat;
    logic signed [127:0] got;
    fill_const(8'h3c, 8'h3c);
    run_job(4, 0, 0, hs, rdy, lat);
    got = res;
    checks++;
    if (rdy != 4 || hs != 4) begin
      errors++;
      $display("FAIL stream_ready_cycles: ready=%0d hs=%0d, required 4 4", rdy, hs);
    end
    checks++;
    if (lat != 2 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_latency: edges=%0d valid=%b, required 2 1", lat, res_valid);
    end
    checks++;
    if (got !== 4 * d_one || got !== model_res(4)) begin
      errors++;
      $display("FAIL stream_res: got=%0d, required %0d", got, 4 * d_one);
    end
    checks++;
    if (nan !== 1'b0) begin
      errors++;
      $display("FAIL stream_nan: got=%b, required 0", nan);
    end
    release_res();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_release: valid=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_bubbles_sign;
    int hs, rdy, lat;
    logic signed [127:0] got;
    fill_const(8'h3c, 8'hbc);
    run_job(3, 2, 0, hs, rdy, lat);
    got = res;
    checks++;
    if (hs != 3 || lat != 2) begin
      errors++;
      $display("FAIL bubble_hs: hs=%0d lat=%0d, required 3 2", hs, lat);
    end
    checks++;
    if (got !== -3 * d_one) begin
      errors++;
      $display("FAIL bubble_res: got=%0d, required %0d", got, -3 * d_one);
    end
    release_res();
  endtask

  task automatic test_nan;
    int hs, rdy, lat;
    logic signed [127:0] got;
    fill_rand(0);
    ca[2][5] = 8'h7c;
    run_job(4, 1, 0, hs, rdy, lat);
    got = res;
    checks++;
    if (nan !== 1'b1 || got !== model_res(4)) begin
      errors++;
      $display("FAIL nan_set: nan=%b res=%0d, required 1 %0d", nan, got, model_res(4));
    end
    release_res();
    fill_rand(0);
    run_job(2, 1, 0, hs, rdy, lat);
    got = res;
    checks++;
    if (nan !== 1'b0 || got !== model_res(2)) begin
      errors++;
      $display("FAIL nan_clear: nan=%b res=%0d, required 0 %0d", nan, got, model_res(2));
    end
    release_res();
  endtask

  task automatic test_zero_busy;
    int hs, rdy, lat;
    logic signed [127:0] got, held;
    run_job(0, 0, 0, hs, rdy, lat);
    checks++;
    if (lat != 1 || res_valid !== 1'b1 || res !== '0 || nan !== 1'b0 || hs != 0) begin
      errors++;
      $display("FAIL zero_len: lat=%0d valid=%b res=%0d nan=%b, required 1 1 0 0", lat, res_valid, res, nan);
    end
    start = 1; num = 5'd3; res_ready = 1;
    @(negedge clk);
    start = 0; res_ready = 0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_on_release: busy=%b valid=%b, required 0 0", busy, res_valid);
    end
    fill_rand(0);
    run_job(3, 1, 1, hs, rdy, lat);
    got = res;
    checks++;
    if (hs != 3 || got !== model_res(3)) begin
      errors++;
      $display("FAIL start_in_load: hs=%0d res=%0d, required 3 %0d", hs, got, model_res(3));
    end
    held = model_res(3);
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      @(negedge clk);
      got = res;
      checks++;
      if (got !== held || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold: res=%0d valid=%b, required %0d 1", got, res_valid, held);
      end
    end
    start = 0;
    release_res();
  endtask

  task automatic test_random;
    int n, hs, rdy, lat;
    logic signed [127:0] got;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(20, 1);
      fill_rand(1);
      run_job(n, 1, 0, hs, rdy, lat);
      got = res;
      checks++;
      if (hs != eff(n) || lat != 2) begin
        errors++;
        $display("FAIL rand_hs n=%0d: hs=%0d lat=%0d, required %0d 2", n, hs, lat, eff(n));
      end
      checks++;
      if (got !== model_res(n) || nan !== model_nan(n)) begin
        errors++;
        $display("FAIL rand_res n=%0d: res=%0d nan=%b, required %0d %b", n, got, nan, model_res(n), model_nan(n));
      end
      release_res();
    end
  endtask

  task automatic test_reset_mid_load;
    int hs, rdy, lat;
    logic signed [127:0] got;
    fill_const(8'h3c, 8'h3c);
    start = 1; num = 5'd4;
    @(negedge clk);
    start = 0; vec_valid = 1;
    for (int l = 0; l < K; l++) begin
      va[l] = 8'h3c;
      vb[l] = 8'h3c;
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, vec_ready, res_valid, nan} !== 4'b0 || res !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: flags=%b res=%0d, required 0000 0", {busy, vec_ready, res_valid, nan}, res);
    end
    vec_valid = 0;
    @(negedge clk);
    rst_n = 1;
    run_job(2, 0, 0, hs, rdy, lat);
    got = res;
    checks++;
    if (hs != 2 || got !== 2 * d_one || nan !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_job: hs=%0d res=%0d nan=%b, required 2 %0d 0", hs, got, nan, 2 * d_one);
    end
    release_res();
  endtask

  initial begin
    d_one = 128'sd1 <<< 37;
    va = '0; vb = '0;
    test_reset();
    test_stream_pos();
    test_bubbles_sign();
    test_nan();
    test_zero_busy();
    test_random();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
